uart_tx_arbiter: RTL

- Shares the single UART transmitter between two byte sources.
  - Source 0 is the switch/button path: sw[7:0] captured on btnC.
  - Source 1 is the PS/2 keyboard scan-code path.
- Each source has a small FIFO. A round-robin scheduler launches one byte at a time into the transmitter using a start/busy handshake.
- Reports each completed byte (value and source) for the seven-segment display logic.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/arb_byte_fifo.sv | 52 +++++
 rtl/uart_tx_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-source UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam logic SRC_SW  = 1'b0;
  localparam logic SRC_PS2 = 1'b1;

  // Completed-frame report consumed by the seven-segment display logic.
  typedef struct packed {
    logic              src;
    logic [BYTE_W-1:0] data;
  } sent_rec_t;

endpackage

// File: rtl/arb_byte_fifo.sv
// Small per-source byte FIFO; full/empty decode straight from the registered count,
// so ready never depends combinationally on the writer's valid.
module arb_byte_fifo
  import uart_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head_c,
  output logic              o_full_c,
  output logic              o_empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;

  // Simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the switch and PS/2 byte sources.
// Optional macro TX_WATCHDOG_EN adds a tx_busy-rise timeout with a sticky tx_err flag.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s0_valid,
  input  logic [BYTE_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [BYTE_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              sent_pulse,
  output logic [BYTE_W-1:0] sent_data,
  output logic              sent_src,
  output logic [1:0]        drop,
  output logic              tx_err
);

  localparam logic [1:0] ST_IDLE      = 2'(IDLE);
  localparam logic [1:0] ST_LAUNCH    = 2'(LAUNCH);
  localparam logic [1:0] ST_WAIT_BUSY = 2'(WAIT_BUSY);
  localparam logic [1:0] ST_WAIT_DONE = 2'(WAIT_DONE);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  logic [1:0]        r_state, w_state_nxt;
  logic              r_last_src, w_last_src_nxt;
  logic              r_cur_src, w_cur_src_nxt;
  logic [BYTE_W-1:0] r_tx_data, w_tx_data_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic              r_sent_pulse, w_sent_pulse_nxt;
  sent_rec_t         r_sent, w_sent_nxt;
  logic [1:0]        r_drop;

  logic [1:0]        w_push, w_pop, w_full, w_empty;
  logic [BYTE_W-1:0] w_head0, w_head1;
  logic              w_any, w_sel, w_wd_expire;

  arb_byte_fifo #(.DEPTH(DEPTH)) u_fifo_sw (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_push   (w_push[0]),
    .i_data   (s0_data),
    .i_pop    (w_pop[0]),
    .o_head_c (w_head0),
    .o_full_c (w_full[0]),
    .o_empty_c(w_empty[0])
  );

  arb_byte_fifo #(.DEPTH(DEPTH)) u_fifo_ps2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_push   (w_push[1]),
    .i_data   (s1_data),
    .i_pop    (w_pop[1]),
    .o_head_c (w_head1),
    .o_full_c (w_full[1]),
    .o_empty_c(w_empty[1])
  );

  assign s0_ready  = !w_full[0];
  assign s1_ready  = !w_full[1];
  assign w_push[0] = s0_valid && !w_full[0];
  assign w_push[1] = s1_valid && !w_full[1];

  // On a tie the source that did not go last wins.
  assign w_any = !w_empty[0] || !w_empty[1];
  assign w_sel = (!w_empty[0] && !w_empty[1]) ? !r_last_src
               : (w_empty[SRC_SW] ? SRC_PS2 : SRC_SW);

`ifdef TX_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_tx_err;

  assign w_wd_expire = (r_state == ST_WAIT_BUSY) && !tx_busy &&
                       (r_wd_cnt == WD_W'(TIMEOUT - 1));
  assign tx_err      = r_tx_err;

  // Counts idle WAIT_BUSY cycles; cleared whenever the arbiter is elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
      r_tx_err <= 1'b0;
    end else begin
      if (r_state == ST_WAIT_BUSY && !tx_busy && !w_wd_expire) r_wd_cnt <= r_wd_cnt + WD_W'(1);
      else                                                     r_wd_cnt <= '0;
      if (w_wd_expire) r_tx_err <= 1'b1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
  assign tx_err      = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_src_nxt   = r_last_src;
    w_cur_src_nxt    = r_cur_src;
    w_tx_data_nxt    = r_tx_data;
    w_tx_start_nxt   = 1'b0;
    w_sent_pulse_nxt = 1'b0;
    w_sent_nxt       = r_sent;
    w_pop            = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_pop         = w_sel ? 2'b10 : 2'b01;
          w_tx_data_nxt = w_sel ? w_head1 : w_head0;
          w_cur_src_nxt = w_sel;
          w_state_nxt   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (w_wd_expire) begin
          w_last_src_nxt = r_cur_src;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          w_sent_pulse_nxt = 1'b1;
          w_sent_nxt.src   = r_cur_src;
          w_sent_nxt.data  = r_tx_data;
          w_last_src_nxt   = r_cur_src;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_src   <= SRC_PS2;
      r_cur_src    <= SRC_SW;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_sent_pulse <= 1'b0;
      r_sent       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_src   <= w_last_src_nxt;
      r_cur_src    <= w_cur_src_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_sent_pulse <= w_sent_pulse_nxt;
      r_sent       <= w_sent_nxt;
    end
  end

  // Sticky overflow flags; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_drop <= 2'b00;
    else          r_drop <= r_drop | {s1_valid && w_full[1], s0_valid && w_full[0]};
  end

  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign sent_pulse = r_sent_pulse;
  assign sent_data  = r_sent.data;
  assign sent_src   = r_sent.src;
  assign drop       = r_drop;

endmodule
